// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath defaults and queue-control types.
//   DATA_W / OPCODE_W / BUS_W : default instruction, opcode and bus widths
//   OP_NOP                    : opcode presented when no instruction is held
//   q_op_e                    : queue action taken on a clock edge
package cpu_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned BUS_W    = 8;

   localparam int unsigned OP_NOP   = 0;

   typedef enum logic [1:0] {
      Q_HOLD = 2'b00,
      Q_POP  = 2'b01,
      Q_PUSH = 2'b10,
      Q_SWAP = 2'b11   // push and pop together: count unchanged
   } q_op_e;

endpackage

// File: rtl/instruction_queue_reg_if.sv
// instruction_queue_reg_if: fetch/consume signals of the instruction queue.
//   master : drives bus_in, ir_in, ir_next, ir_flush, ir_out
//   slave  : the queue; returns head opcode, valid/full/count/overflow status
interface instruction_queue_reg_if #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned OPCODE_W = 4,
   parameter int unsigned DEPTH    = 4
);
   logic [DATA_W-1:0]            bus_in;
   logic                         ir_in;
   logic                         ir_next;
   logic                         ir_flush;
   logic                         ir_out;
   logic [OPCODE_W-1:0]          instruction_to_control;
   logic                         ir_valid;
   logic                         ir_full;
   logic [$clog2(DEPTH+1)-1:0]   ir_count;
   logic                         ir_overflow;

   modport master (
      output bus_in, ir_in, ir_next, ir_flush, ir_out,
      input  instruction_to_control, ir_valid, ir_full, ir_count, ir_overflow
   );

   modport slave (
      input  bus_in, ir_in, ir_next, ir_flush, ir_out,
      output instruction_to_control, ir_valid, ir_full, ir_count, ir_overflow
   );
endinterface

// File: rtl/instr_queue_storage.sv
// instr_queue_storage: DEPTH x DATA_W register array for the instruction queue.
//   clock   : rising-edge write clock
//   wr_en   : write wr_data at wr_addr
//   rd_addr : head pointer; rd_data is the asynchronous read of that entry
// Contents are not reset; validity is tracked by the owning queue's count.
module instr_queue_storage #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instruction_queue_reg.sv
// instruction_queue_reg: in-order instruction prefetch queue.
//   clock, clear : rising-edge clock, synchronous active-high reset
//   iq (slave)   : bus_in/ir_in push, ir_next pop, ir_flush discard, ir_out
//                  operand drive enable; head opcode, valid/full/count and
//                  sticky overflow status
//   bus_out      : extended head operand while ir_out=1, otherwise Z
// bus_out is a direct port so the tri-state resolves at the module boundary.
module instruction_queue_reg #(
   parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
   parameter int unsigned OPCODE_W = cpu_pkg::OPCODE_W,
   parameter int unsigned BUS_W    = cpu_pkg::BUS_W,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned SIGN_EXT = 0
) (
   input  logic                   clock,
   input  logic                   clear,
   instruction_queue_reg_if.slave iq,
   output logic [BUS_W-1:0]       bus_out
);
   import cpu_pkg::*;

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = $clog2(DEPTH+1);
   localparam int unsigned OPR_W = DATA_W - OPCODE_W;

   logic [AW-1:0]     head_q, head_d;
   logic [AW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;

   logic              pop_ok, push_ok, is_full;
   q_op_e             q_op;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] head_word;
   logic [OPR_W-1:0]  operand;
   logic [BUS_W-1:0]  operand_ext;

   instr_queue_storage #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_storage (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (iq.bus_in),
      .rd_addr (head_q),
      .rd_data (head_word)
   );

   // A full queue still accepts a push when the head leaves on the same edge.
   always_comb begin
      is_full = (count_q == CW'(DEPTH));
      pop_ok  = iq.ir_next && (count_q != '0);
      push_ok = iq.ir_in && (!is_full || pop_ok);
      q_op    = q_op_e'({push_ok, pop_ok});
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      wr_addr = tail_q;
      if (clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (iq.ir_flush) begin
         // Branch target fetched in the flush cycle becomes the sole entry.
         head_d  = '0;
         ovf_d   = 1'b0;
         wr_addr = '0;
         if (iq.ir_in) begin
            wr_en   = 1'b1;
            tail_d  = AW'(1);
            count_d = CW'(1);
         end else begin
            tail_d  = '0;
            count_d = '0;
         end
      end else begin
         if (iq.ir_in && !push_ok) begin
            ovf_d = 1'b1;
         end
         case (q_op)
            Q_PUSH: begin
               wr_en   = 1'b1;
               tail_d  = tail_q + AW'(1);
               count_d = count_q + CW'(1);
            end
            Q_POP: begin
               head_d  = head_q + AW'(1);
               count_d = count_q - CW'(1);
            end
            Q_SWAP: begin
               wr_en   = 1'b1;
               tail_d  = tail_q + AW'(1);
               head_d  = head_q + AW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
   end

   always_comb begin
      iq.ir_valid    = (count_q != '0);
      iq.ir_full     = is_full;
      iq.ir_count    = count_q;
      iq.ir_overflow = ovf_q;
      if (count_q != '0) begin
         iq.instruction_to_control = head_word[DATA_W-1 -: OPCODE_W];
         operand                   = head_word[OPR_W-1:0];
      end else begin
         iq.instruction_to_control = OPCODE_W'(OP_NOP);
         operand                   = '0;
      end
      // Size-casting a signed value replicates its MSB.
      if (SIGN_EXT != 0) begin
         operand_ext = BUS_W'($signed(operand));
      end else begin
         operand_ext = BUS_W'(operand);
      end
   end

   assign bus_out = iq.ir_out ? operand_ext : 'z;

endmodule

// File: tb/tb_instruction_queue_reg.sv
module tb_instruction_queue_reg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned BUS_W    = 8;
   localparam int unsigned DEPTH    = 4;
   // bus_out nets are tri1, so an undriven (Z) bus reads as all ones here.
   localparam logic [7:0]  BZ       = 8'hFF;

   logic clock = 1'b0;
   logic clear = 1'b0;
   always #5 clock = ~clock;

   instruction_queue_reg_if #(.DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .DEPTH(DEPTH)) iq ();
   instruction_queue_reg_if #(.DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .DEPTH(DEPTH)) iq_sx ();

   tri1 [BUS_W-1:0] bus_out;
   tri1 [BUS_W-1:0] bus_out_sx;

   instruction_queue_reg #(
      .DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .SIGN_EXT(0)
   ) dut (
      .clock(clock), .clear(clear), .iq(iq), .bus_out(bus_out)
   );

   instruction_queue_reg #(
      .DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .BUS_W(BUS_W), .DEPTH(DEPTH), .SIGN_EXT(1)
   ) dut_sx (
      .clock(clock), .clear(clear), .iq(iq_sx), .bus_out(bus_out_sx)
   );

   typedef struct {
      string      name;
      logic [2:0] cnt;
      logic [3:0] op;
      logic       ovf;
      logic [7:0] bus;
      logic       chk_sx;
      logic [7:0] sx_bus;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic cmp(input string name, input string fld, input logic [31:0] got,
                      input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s.%s got=%0h expected=%0h", name, fld, got, want);
      end
   endtask

   // Monitor: one expected record is consumed per clock edge, 1 time unit
   // after the edge, while the stimulus that produced it is still applied.
   always @(posedge clock) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         cmp(mon_e.name, "count",  32'(iq.ir_count),               32'(mon_e.cnt));
         cmp(mon_e.name, "valid",  32'(iq.ir_valid),               32'(mon_e.cnt != 0));
         cmp(mon_e.name, "full",   32'(iq.ir_full),                32'(mon_e.cnt == 4));
         cmp(mon_e.name, "opcode", 32'(iq.instruction_to_control), 32'(mon_e.op));
         cmp(mon_e.name, "ovf",    32'(iq.ir_overflow),            32'(mon_e.ovf));
         cmp(mon_e.name, "bus",    32'(bus_out),                   32'(mon_e.bus));
         if (mon_e.chk_sx) begin
            cmp(mon_e.name, "bus_sx", 32'(bus_out_sx), 32'(mon_e.sx_bus));
         end
      end
   end

   task automatic drive(input logic [7:0] bin, input logic p_in, input logic p_nxt,
                        input logic p_fl, input logic p_out, input logic p_clr);
      clear       = p_clr;
      iq.bus_in   = bin;   iq_sx.bus_in   = bin;
      iq.ir_in    = p_in;  iq_sx.ir_in    = p_in;
      iq.ir_next  = p_nxt; iq_sx.ir_next  = p_nxt;
      iq.ir_flush = p_fl;  iq_sx.ir_flush = p_fl;
      iq.ir_out   = p_out; iq_sx.ir_out   = p_out;
   endtask

   // Applies one cycle of stimulus and queues the hand-computed state
   // expected after the next rising edge.
   task automatic step(input string name, input logic [7:0] bin, input logic p_in,
                       input logic p_nxt, input logic p_fl, input logic p_out,
                       input logic p_clr, input int cnt, input int op, input logic ovf,
                       input logic [7:0] bus, input logic chk_sx = 1'b0,
                       input logic [7:0] sx_bus = 8'h00);
      exp_t e;
      @(negedge clock);
      drive(bin, p_in, p_nxt, p_fl, p_out, p_clr);
      e.name = name; e.cnt = 3'(cnt); e.op = 4'(op); e.ovf = ovf; e.bus = bus;
      e.chk_sx = chk_sx; e.sx_bus = sx_bus;
      exp_q.push_back(e);
      @(posedge clock);
   endtask

   initial begin
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      //    name          bus_in in  nxt fl  out clr  cnt op   ovf  bus
      step("reset",       8'h00, 0,  0,  0,  0,  1,   0,  0,   0,   BZ);
      step("reset_drv",   8'h00, 0,  0,  0,  1,  1,   0,  0,   0,   8'h00);
      step("push3a",      8'h3A, 1,  0,  0,  1,  0,   1,  3,   0,   8'h0A);
      step("hold3a_z",    8'h00, 0,  0,  0,  0,  0,   1,  3,   0,   BZ);
      step("clr2",        8'h00, 0,  0,  0,  0,  1,   0,  0,   0,   BZ);
      step("push11",      8'h11, 1,  0,  0,  0,  0,   1,  1,   0,   BZ);
      step("push22",      8'h22, 1,  0,  0,  0,  0,   2,  1,   0,   BZ);
      step("push33",      8'h33, 1,  0,  0,  0,  0,   3,  1,   0,   BZ);
      step("push44",      8'h44, 1,  0,  0,  0,  0,   4,  1,   0,   BZ);
      step("push55_drop", 8'h55, 1,  0,  0,  1,  0,   4,  1,   1,   8'h01);
      step("pop_a",       8'h00, 0,  1,  0,  1,  0,   3,  2,   1,   8'h02);
      step("pop_b",       8'h00, 0,  1,  0,  1,  0,   2,  3,   1,   8'h03);
      step("pop_c",       8'h00, 0,  1,  0,  1,  0,   1,  4,   1,   8'h04);
      step("pop_d",       8'h00, 0,  1,  0,  1,  0,   0,  0,   1,   8'h00);
      step("pop_empty",   8'h00, 0,  1,  0,  1,  0,   0,  0,   1,   8'h00);
      step("refill11",    8'h11, 1,  0,  0,  0,  0,   1,  1,   1,   BZ);
      step("refill22",    8'h22, 1,  0,  0,  0,  0,   2,  1,   1,   BZ);
      step("refill33",    8'h33, 1,  0,  0,  0,  0,   3,  1,   1,   BZ);
      step("refill44",    8'h44, 1,  0,  0,  0,  0,   4,  1,   1,   BZ);
      step("full_swap99", 8'h99, 1,  1,  0,  1,  0,   4,  2,   1,   8'h02);
      step("wrap_pop33",  8'h00, 0,  1,  0,  1,  0,   3,  3,   1,   8'h03);
      step("wrap_pop44",  8'h00, 0,  1,  0,  1,  0,   2,  4,   1,   8'h04);
      step("wrap_pop99",  8'h00, 0,  1,  0,  1,  0,   1,  9,   1,   8'h09);
      step("wrap_empty",  8'h00, 0,  1,  0,  1,  0,   0,  0,   1,   8'h00);
      step("fill_a1",     8'hA1, 1,  0,  0,  0,  0,   1,  10,  1,   BZ);
      step("fill_b2",     8'hB2, 1,  0,  0,  0,  0,   2,  10,  1,   BZ);
      step("fill_c3",     8'hC3, 1,  0,  0,  0,  0,   3,  10,  1,   BZ);
      step("flush_7c",    8'h7C, 1,  1,  1,  1,  0,   1,  7,   0,   8'h0C);
      step("swap_2e",     8'h2E, 1,  1,  0,  1,  0,   1,  2,   0,   8'h0E, 1'b1, 8'hFE);
      step("flush_only",  8'h00, 0,  0,  1,  1,  0,   0,  0,   0,   8'h00);
      step("push_pop_mt", 8'h5D, 1,  1,  0,  1,  0,   1,  5,   0,   8'h0D);
      step("push6e",      8'h6E, 1,  0,  0,  0,  0,   2,  5,   0,   BZ);
      step("push7f",      8'h7F, 1,  0,  0,  0,  0,   3,  5,   0,   BZ);
      step("push80",      8'h80, 1,  0,  0,  0,  0,   4,  5,   0,   BZ);
      step("push91_drop", 8'h91, 1,  0,  0,  0,  0,   4,  5,   1,   BZ);
      step("clr_all",     8'hF0, 1,  1,  1,  0,  1,   0,  0,   0,   BZ);
      step("idle_drv",    8'h00, 0,  0,  0,  1,  0,   0,  0,   0,   8'h00);
      @(negedge clock);
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clock);
      cmp("scoreboard", "drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_queue_reg.md
# instruction_queue_reg

Parametrised successor to the single-entry instruction register: a small in-order prefetch queue of instruction words between the data bus and the control sequencer. Fetch loads words from the bus; the control unit consumes the head entry, whose opcode field goes to control and whose operand field can be driven onto the shared tri-state bus. A flush path discards prefetched words on a branch or jump.

## Interface
Parameters:
- `DATA_W`, 8: instruction word width.
- `OPCODE_W`, 4: opcode field width, taken from bits [DATA_W-1 : DATA_W-OPCODE_W].
- `BUS_W`, 8: width of the bus_out operand drive. Must satisfy BUS_W ≥ DATA_W-OPCODE_W.
- `DEPTH`, 4: queue entries. Power of two, ≥ 2.
- `SIGN_EXT`, 0: 0 zero-extends the operand to BUS_W; 1 sign-extends it.

Ports (clock and reset first):
- `clock` in 1: single clock, all state updates on the rising edge.
- `clear` in 1: reset, synchronous and active-high.
- `bus_in` in DATA_W: instruction word from the bus.
- `ir_in` in 1: push bus_in into the queue tail.
- `ir_next` in 1: pop the head, advancing to the next instruction.
- `ir_flush` in 1: discard all entries.
- `ir_out` in 1: drive the head operand onto bus_out.
- `bus_out` out BUS_W: extended head operand when ir_out=1, otherwise all Z.
- `instruction_to_control` out OPCODE_W: head opcode; 0 when the queue is empty.
- `ir_valid` out 1: queue is non-empty.
- `ir_full` out 1: count == DEPTH.
- `ir_count` out $clog2(DEPTH+1): number of entries held.
- `ir_overflow` out 1: sticky flag, set when a push is dropped.

## Operation
- Circular storage with head and tail pointers and an explicit count; the count disambiguates full from empty.
- Priority per edge: clear > flush > push/pop.
- Clear:
  - Count, pointers and ir_overflow go to 0. Storage contents are don't-care.
  - All outputs reach reset values: ir_valid=0, ir_full=0, ir_count=0, instruction_to_control=0, ir_overflow=0. bus_out is Z when ir_out=0 and 0 when ir_out=1.
- Flush:
  - Count and pointers go to 0; ir_overflow clears.
  - If ir_in is also high, bus_in becomes the sole entry (count=1). This is the branch-target fetch in the same cycle.
  - ir_next is ignored during a flush.
- Push: accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle. Otherwise the word is dropped and ir_overflow is set.
- Pop: accepted only when count > 0. A pop on an empty queue is ignored and sets no flag.
- Simultaneous push and pop on a non-empty queue: count unchanged, head advances, and the word is written at the tail.
- Push and pop on an empty queue: pop ignored, push takes effect (count=1).
- Operand extension: operand = head[DATA_W-OPCODE_W-1:0], zero- or sign-extended to BUS_W according to SIGN_EXT. When the queue is empty the operand is 0.
- Pointers wrap modulo DEPTH with no gap.

## Timing
- Outputs ir_valid, ir_full, ir_count, ir_overflow and instruction_to_control are registered/state-derived and change only after a clock edge.
- Push-to-head latency: 1 cycle when the queue is empty. A word pushed at edge N appears on instruction_to_control after edge N.
- A pop at edge N presents the next entry after edge N, with no bubble.
- bus_out is combinational from ir_out and the head entry. It reaches Z within the same cycle that ir_out falls.
- Clear asserted mid-stream takes effect at the next edge regardless of ir_in, ir_next or ir_flush.
- Sustained throughput: one push and one pop per cycle.

## Structure
- Shared package `cpu_pkg`:
  - Default widths (DATA_W, OPCODE_W, BUS_W).
  - Opcode constant `OP_NOP` = 0, which is the value presented when the queue is empty.
- One natural sub-module: `instr_queue_storage`, holding the DEPTH×DATA_W register array, write port and head read port.
- Pointer and count control, flags, operand extension and tri-state drive stay in the top module.

## Test plan
- Reset, then push 0x3A: after one edge instruction_to_control=0x3, ir_valid=1, ir_count=1. With ir_out=1, bus_out=0x0A; with ir_out=0, bus_out=Z.
- Push 0x11, 0x22, 0x33, 0x44, then 0x55 with DEPTH=4: ir_full=1, ir_overflow=1, 0x55 discarded. Four pops then return opcodes 1, 2, 3, 4 in order, and ir_valid=0 afterwards.
- Full queue with push 0x99 and pop in the same cycle: count stays 4, head becomes 0x22 and the tail holds 0x99. Then pop repeatedly through a pointer wrap and confirm the order is preserved.
- Three entries held, then ir_flush with ir_in and bus_in=0x7C: ir_count=1, opcode=0x7, ir_overflow=0.
- SIGN_EXT=1, BUS_W=8, push 0x2E: bus_out=0xFE when ir_out=1. The same word with SIGN_EXT=0 gives bus_out=0x0E.
- Pop on an empty queue, and clear asserted together with push, pop and flush: the empty-queue pop leaves state unchanged, and the clear forces all outputs to reset values at the next edge.
